// File: rtl/data_sram_like_slave.sv
`default_nettype none
// ============================================================================
// data_sram_like_slave : SRAM-like data-bus responder with a byte-strobed word
//                        array and an in-order response FIFO.
// Revision 1.0
// ============================================================================
module data_sram_like_slave #(
   parameter int IDX_W = 10,
   parameter int OUTST = 2
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    data_sram_req,
   input  logic                    data_sram_wr,
   input  logic [1:0]              data_sram_size,
   input  logic [31:0]             data_sram_addr,
   input  logic [3:0]              data_sram_wstrb,
   input  logic [31:0]             data_sram_wdata,
   output logic                    data_sram_addr_ok,
   output logic                    data_sram_data_ok,
   output logic [31:0]             data_sram_rdata,
   input  logic                    stall_addr,
   input  logic                    stall_data,
   output logic [$clog2(OUTST):0]  outstanding
);

   localparam int CNT_W = $clog2(OUTST) + 1;
   localparam int PTR_W = (OUTST > 1) ? $clog2(OUTST) : 1;
   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTST - 1);

   logic [31:0]      mem_q [DEPTH];
   logic [31:0]      resp_q [OUTST];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic [IDX_W-1:0] idx;
   logic             unused_bits;

   // Size and the non-index address bits are informational only.
   assign unused_bits = ^{data_sram_size, data_sram_addr};

   assign idx               = data_sram_addr[IDX_W+1:2];
   assign data_sram_addr_ok = resetn && !stall_addr && (cnt_q != FULL_CNT);
   assign data_sram_data_ok = (cnt_q != '0) && !stall_data;
   assign data_sram_rdata   = data_sram_data_ok ? resp_q[head_q] : 32'h0;
   assign accept            = data_sram_req && data_sram_addr_ok;
   assign outstanding       = cnt_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (accept) begin
         tail_d = ptr_inc(tail_q);
      end
      if (data_sram_data_ok) begin
         head_d = ptr_inc(head_q);
      end
      case ({accept, data_sram_data_ok})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Array and FIFO payload are not reset; a read captures the pre-write word.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
               if (data_sram_wstrb[i]) begin
                  mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
               end
            end
         end
         resp_q[tail_q] <= data_sram_wr ? 32'h0 : mem_q[idx];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_like_slave.sv
`default_nettype none
// Bench for data_sram_like_slave: directed scenarios plus random traffic checked
// every cycle against a queue/array model of the bus.
module tb_data_sram_like_slave;

   localparam int IDX_W = 10;
   localparam int OUTST = 2;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd2;
   logic [31:0] addr = 32'h0;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall_addr = 1'b0;
   logic        stall_data = 1'b0;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;
   logic [$clog2(OUTST):0] outstanding;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_sram_like_slave #(.IDX_W(IDX_W), .OUTST(OUTST)) dut (
      .clk(clk), .resetn(resetn),
      .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
      .data_sram_addr(addr), .data_sram_wstrb(wstrb), .data_sram_wdata(wdata),
      .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok),
      .data_sram_rdata(rdata),
      .stall_addr(stall_addr), .stall_data(stall_data),
      .outstanding(outstanding)
   );

   logic [31:0] mm [int];
   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   bit          last_accept = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] got(input int i);
      return (i < got_q.size()) ? got_q[i] : 32'hDEAD_DEAD;
   endfunction

   // Model: expected outputs from queue occupancy; state advances as the next edge will.
   logic        e_aok, e_dok;
   logic [31:0] e_rd, cur;
   int          midx;
   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_addr_ok", 32'(addr_ok), 32'h0);
         chk("rst_data_ok", 32'(data_ok), 32'h0);
         chk("rst_rdata", rdata, 32'h0);
         chk("rst_outstanding", 32'(outstanding), 32'h0);
         exp_q.delete();
         last_accept = 1'b0;
      end else begin
         e_aok = !stall_addr && (exp_q.size() < OUTST);
         e_dok = (exp_q.size() != 0) && !stall_data;
         e_rd  = e_dok ? exp_q[0] : 32'h0;
         chk("addr_ok", 32'(addr_ok), 32'(e_aok));
         chk("data_ok", 32'(data_ok), 32'(e_dok));
         chk("outstanding", 32'(outstanding), exp_q.size());
         if (!$isunknown(e_rd)) chk("rdata", rdata, e_rd);
         if (data_ok === 1'b1) got_q.push_back(rdata);
         if (e_dok) void'(exp_q.pop_front());
         last_accept = req && e_aok;
         if (last_accept) begin
            midx = int'((addr >> 2) % (1 << IDX_W));
            cur  = mm.exists(midx) ? mm[midx] : 32'hxxxx_xxxx;
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
               mm[midx] = cur;
               exp_q.push_back(32'h0);
            end else begin
               exp_q.push_back(cur);
            end
         end
      end
   end

   task automatic do_req(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
      int n = 0;
      req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
      @(negedge clk);
      while (addr_ok !== 1'b1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) chk("accept_wait", 32'(addr_ok), 32'h1);
      @(posedge clk); #1;
      req = 1'b0; wr = 1'b0; wstrb = 4'h0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((outstanding !== '0 || exp_q.size() != 0) && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("drain", 32'(outstanding), 32'h0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("reset_addr_ok", 32'(addr_ok), 32'h0);
      chk("reset_outstanding", 32'(outstanding), 32'h0);
      repeat (3) @(posedge clk);
      #3 resetn = 1'b1;
      @(posedge clk); #1;

      // T1 write then read
      got_q.delete();
      do_req(1'b1, 32'h10, 4'hF, 32'h1122_3344);
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      wait_idle();
      chk("t1_count", got_q.size(), 32'd2);
      chk("t1_wr_resp", got(0), 32'h0);
      chk("t1_rd", got(1), 32'h1122_3344);

      // T2 byte/half strobes
      got_q.delete();
      do_req(1'b1, 32'h12, 4'b0100, 32'hAAAA_AAAA);
      do_req(1'b1, 32'h10, 4'b0011, 32'hBBBB_BBBB);
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      do_req(1'b1, 32'h14, 4'hF, 32'hCAFE_F00D);
      wait_idle();
      chk("t2_rd", got(2), 32'h11AA_BBBB);

      // T3 full FIFO with stalled responses; a pop frees no slot that cycle
      got_q.delete();
      stall_data = 1'b1;
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      do_req(1'b0, 32'h14, 4'h0, 32'h0);
      req = 1'b1; wr = 1'b0; addr = 32'h10;
      repeat (3) begin
         @(negedge clk);
         chk("t3_full_aok", 32'(addr_ok), 32'h0);
         chk("t3_occ", 32'(outstanding), 32'd2);
      end
      @(posedge clk); #1 stall_data = 1'b0;
      @(negedge clk);
      chk("t3_pop1", 32'(data_ok), 32'h1);
      chk("t3_nofree", 32'(addr_ok), 32'h0);
      @(negedge clk);
      chk("t3_accept", 32'(addr_ok), 32'h1);
      chk("t3_pop2", 32'(data_ok), 32'h1);
      @(posedge clk); #1 req = 1'b0;
      wait_idle();
      chk("t3_count", got_q.size(), 32'd3);
      chk("t3_r0", got(0), 32'h11AA_BBBB);
      chk("t3_r1", got(1), 32'hCAFE_F00D);
      chk("t3_r2", got(2), 32'h11AA_BBBB);

      // T4 latency exactly one cycle
      req = 1'b1; wr = 1'b0; addr = 32'h14;
      @(negedge clk);
      chk("t4_aok", 32'(addr_ok), 32'h1);
      chk("t4_no_bypass", 32'(data_ok), 32'h0);
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("t4_dok", 32'(data_ok), 32'h1);
      chk("t4_rdata", rdata, 32'hCAFE_F00D);
      @(posedge clk); #1;

      // T5 address stall with request held
      stall_addr = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h10;
      repeat (5) begin
         @(negedge clk);
         chk("t5_aok", 32'(addr_ok), 32'h0);
         chk("t5_dok", 32'(data_ok), 32'h0);
      end
      @(posedge clk); #1 stall_addr = 1'b0;
      @(negedge clk);
      chk("t5_release", 32'(addr_ok), 32'h1);
      @(posedge clk); #1 req = 1'b0;
      wait_idle();

      // T6 asynchronous reset with two reads outstanding
      stall_data = 1'b1;
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      do_req(1'b0, 32'h14, 4'h0, 32'h0);
      got_q.delete();
      stall_data = 1'b0;
      #1 chk("t6_pre_dok", 32'(data_ok), 32'h1);
      #1 resetn = 1'b0;
      #1;
      chk("t6_dok_now", 32'(data_ok), 32'h0);
      chk("t6_aok_now", 32'(addr_ok), 32'h0);
      chk("t6_occ_now", 32'(outstanding), 32'h0);
      @(posedge clk); #3 resetn = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("t6_no_stale", 32'(data_ok), 32'h0);
      end
      @(posedge clk); #1;
      chk("t6_no_resp", got_q.size(), 32'd0);
      do_req(1'b0, 32'h10, 4'h0, 32'h0);
      wait_idle();
      chk("t6_persist", got(0), 32'h11AA_BBBB);

      // Random traffic over words 4..11 (all pre-initialised)
      for (int k = 6; k < 12; k++) do_req(1'b1, 32'(k * 4), 4'hF, $urandom());
      wait_idle();
      for (int k = 0; k < 600; k++) begin
         if (!req || last_accept) begin
            if ($urandom_range(0, 3) != 0) begin
               logic [31:0] a;
               a = $urandom();
               a[11:2] = 10'(4 + $urandom_range(0, 7));
               req = 1'b1; wr = 1'($urandom_range(0, 1)); addr = a;
               wstrb = 4'($urandom()); wdata = $urandom();
            end else begin
               req = 1'b0;
            end
         end
         stall_addr = ($urandom_range(0, 3) == 0);
         stall_data = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
      end
      req = 1'b0; stall_addr = 1'b0; stall_data = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
